issue_select: RTL
=================

Name: issue_select

Overview:
- Consumer end of the DependencyMatrix wakeup interface.
- Each cycle it samples the matrix's ready_vector and selects the oldest ready, un-issued entry. It holds that entry in a registered issue slot and hands it to a functional unit with a valid/ready handshake.
- After the handshake it drives the matrix's free port for the issued row. Once the op's latency elapses it broadcasts the row's one-hot column on the matrix's clear port, which wakes up dependants.

Parameters:
- NUM_ROWS, 8, scheduler entries; must be a power of 2 and at least 2.
- LAT_W, 3, width of the per-op latency field.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- alloc_en  in  1  a new op is written into the scheduler row this cycle.
- alloc_row_index  in  $clog2(NUM_ROWS)  row being allocated.
- alloc_lat  in  LAT_W  result latency of the new op.
- flush  in  1  squash all entries.
- ready_vector  in  NUM_ROWS  per-row "all sources ready", from the dependency matrix.
- issue_valid  out  1  issue slot holds a selected op.
- issue_row_index  out  $clog2(NUM_ROWS)  row held in the issue slot.
- issue_ready  in  1  functional unit accepts the op.
- free_en  out  1  pulse: free the matrix row.
- free_row_index  out  $clog2(NUM_ROWS)  row to free.
- clear_en  out  1  clear broadcast is valid.
- clear_lines  out  NUM_ROWS  columns to clear; may be multi-hot.
- busy_vector  out  NUM_ROWS  rows not allocatable (valid, or a wakeup is pending).

Behaviour:
- Reset (rst=0, asynchronous): every output is 0. All valid, issued and timer state is cleared. The age matrix is cleared.
- Per-row state: valid, issued, lat[LAT_W], timer[LAT_W], timer_active. Age matrix: older[i][j]=1 means row i was allocated before row j.
- Allocation (alloc_en=1, no flush):
  - valid[r]=1, issued[r]=0, lat[r]=alloc_lat.
  - older[j][r]=1 for every valid j; older[r][*]=0.
  - Allocating a row whose busy_vector bit is 1 is illegal; the behaviour is undefined and covered by an assertion.
- Eligibility: elig[i] = valid[i] & ready_vector[i] & ~issued[i].
- Select: pick i with elig[i] such that no elig[j] has older[j][i]=1. The result is unique because the age matrix is a total order.
- Issue slot:
  - Loads when empty, or when it is draining this cycle (issue_valid & issue_ready).
  - On load: issue_valid=1, issue_row_index=sel, issued[sel]=1.
  - Select-to-issue_valid latency is 1 cycle. Back-to-back issue at 1 op/cycle is sustained when issue_ready=1.
  - issue_valid and issue_row_index hold stable while issue_ready=0.
- Handshake in cycle N, row r:
  - In cycle N+1, free_en=1 and free_row_index=r for exactly 1 cycle.
  - valid[r] clears at the cycle N edge.
  - timer[r] is loaded with lat[r] and timer_active[r] is set.
- Wakeup:
  - In any cycle where timer_active[r] and timer[r]==0: clear_lines[r]=1, clear_en=1, timer_active[r] clears at the cycle end.
  - Otherwise timer[r] decrements.
  - Net effect: clear is asserted in cycle N+1+lat. lat=0 therefore clears in the same cycle as free_en.
  - Simultaneous expiries are ORed into clear_lines.
  - clear_en=0 implies clear_lines=0.
- busy_vector = valid | timer_active.
- A ready_vector bit for a non-valid row is ignored.
- Flush:
  - Takes effect at the clock edge: all valid, issued and timer_active cleared; issue slot emptied.
  - No free or clear is generated for squashed rows.
  - The flush cycle's outputs are computed from pre-flush state (a handshake in the flush cycle still produces free_en next cycle; that handshake's timer is not started).
  - Flush beats a simultaneous alloc_en.
- Reset mid-operation: every pending free and clear is dropped.

Optional Feature:
- Macro: SELECT_PERF_EN.
- Defined: adds outputs issue_cnt[15:0] and stall_cnt[15:0].
  - issue_cnt increments on each handshake.
  - stall_cnt increments in each cycle with issue_valid & ~issue_ready.
  - Both saturate at 16'hFFFF, are cleared by reset, and are not cleared by flush.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Test Plan:
- Alloc row 7 (lat=2), then row 0 (lat=0); ready_vector=8'b10000001, issue_ready=1 -> row 7 issues first (older). Then row 0 issues. free_en for row 7 is followed by clear_lines=8'b10000000 two cycles later. Row 0's clear_lines=8'b00000001 coincides with its free_en.
- Single ready row 3, issue_ready=0 for 4 cycles -> issue_valid=1 and index 3 held stable; no free_en. Release -> free_en with index 3 on the next cycle.
- Rows 1 (lat=1) and 2 (lat=0) issued on consecutive cycles -> both expire together; clear_lines=8'b00000110 in one cycle.
- Flush while the slot holds row 5 and row 4 has a pending timer -> issue_valid=0 next cycle; no clear for row 4; busy_vector=0.
- Alloc row 6 with alloc_lat=7, issue it -> busy_vector[6]=1 until its clear cycle (handshake+8), then 0.
- Assert rst=0 mid-countdown -> all outputs 0 immediately (asynchronous); no clear after release.

Source files
------------

// File: rtl/issue_select.sv
// issue_select: oldest-ready selection from a scheduler window, a single
// registered issue slot with a valid/ready handshake, a free pulse back to the
// dependency matrix, and per-row latency timers that drive the clear broadcast.
// Optional build macro SELECT_PERF_EN adds saturating issue/stall counters.
module issue_select #(
  parameter int NUM_ROWS = 8,
  parameter int LAT_W    = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_en,
  input  logic [$clog2(NUM_ROWS)-1:0] alloc_row_index,
  input  logic [LAT_W-1:0]            alloc_lat,
  input  logic                        flush,
  input  logic [NUM_ROWS-1:0]         ready_vector,
  output logic                        issue_valid,
  output logic [$clog2(NUM_ROWS)-1:0] issue_row_index,
  input  logic                        issue_ready,
  output logic                        free_en,
  output logic [$clog2(NUM_ROWS)-1:0] free_row_index,
  output logic                        clear_en,
  output logic [NUM_ROWS-1:0]         clear_lines,
  output logic [NUM_ROWS-1:0]         busy_vector
`ifdef SELECT_PERF_EN
  ,
  output logic [15:0]                 issue_cnt,
  output logic [15:0]                 stall_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_ROWS);

  logic [NUM_ROWS-1:0] valid;
  logic [NUM_ROWS-1:0] issued;
  logic [NUM_ROWS-1:0] timer_active;
  logic [LAT_W-1:0]    lat   [NUM_ROWS];
  logic [LAT_W-1:0]    timer [NUM_ROWS];
  logic [NUM_ROWS-1:0] older [NUM_ROWS];

  logic [NUM_ROWS-1:0] elig;
  logic [NUM_ROWS-1:0] sel_vec;
  logic [IDX_W-1:0]    sel_row;
  logic                blocked;
  logic                load;
  logic                hs;
  logic [NUM_ROWS-1:0] expire;

  logic                vld_p0;
  logic [IDX_W-1:0]    row_p0;
  logic                vld_p1;
  logic [IDX_W-1:0]    row_p1;

`ifdef SELECT_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  assign elig = valid & ready_vector & ~issued;
  assign hs   = vld_p0 & issue_ready;
  assign load = (|elig) & (~vld_p0 | hs);

  // Age-matrix select: a row wins when no other eligible row is older than it.
  always_comb begin
    sel_vec = '0;
    sel_row = '0;
    blocked = 1'b0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < NUM_ROWS; j++) begin
        if (elig[j] && older[j][i]) blocked = 1'b1;
      end
      sel_vec[i] = elig[i] & ~blocked;
    end
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (sel_vec[i]) sel_row = IDX_W'(i);
    end
  end

  // Timer expiry is the clear broadcast; an idle timer contributes nothing.
  always_comb begin
    expire = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      expire[r] = timer_active[r] && (timer[r] == '0);
    end
  end

  assign clear_lines     = expire;
  assign clear_en        = |expire;
  assign busy_vector     = valid | timer_active;
  assign issue_valid     = vld_p0;
  assign issue_row_index = row_p0;
  assign free_en         = vld_p1;
  assign free_row_index  = row_p1;

  // Row lifecycle: allocate sets valid, selection marks issued, handshake retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid  <= '0;
      issued <= '0;
    end else if (flush) begin
      valid  <= '0;
      issued <= '0;
    end else begin
      if (hs)   valid[row_p0]   <= 1'b0;
      if (load) issued[sel_row] <= 1'b1;
      if (alloc_en) begin
        valid[alloc_row_index]  <= 1'b1;
        issued[alloc_row_index] <= 1'b0;
      end
    end
  end

  // Latency field captured at allocation; only read once the row issues.
  always_ff @(posedge clk) begin
    if (alloc_en && !flush) lat[alloc_row_index] <= alloc_lat;
  end

  // Age matrix: the new row is younger than every currently valid row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ROWS; i++) older[i] <= '0;
    end else if (alloc_en && !flush) begin
      for (int j = 0; j < NUM_ROWS; j++) older[j][alloc_row_index] <= valid[j];
      older[alloc_row_index] <= '0;
    end
  end

  // Wakeup timers: count down after the handshake, drop on expiry or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_active <= '0;
      for (int r = 0; r < NUM_ROWS; r++) timer[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (timer_active[r]) begin
          if (timer[r] == '0) timer_active[r] <= 1'b0;
          else                timer[r]        <= timer[r] - LAT_W'(1);
        end
      end
      if (flush) begin
        timer_active <= '0;
      end else if (hs) begin
        timer[row_p0]        <= lat[row_p0];
        timer_active[row_p0] <= 1'b1;
      end
    end
  end

  // Stage p0: issue slot, refilled on the same edge it drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0 <= 1'b0;
      row_p0 <= '0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
    end else if (load) begin
      vld_p0 <= 1'b1;
      row_p0 <= sel_row;
    end else if (hs) begin
      vld_p0 <= 1'b0;
    end
  end

  // Stage p1: one-cycle free pulse for the row that handshook; flush does not cancel it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      row_p1 <= '0;
    end else begin
      vld_p1 <= hs;
      if (hs) row_p1 <= row_p0;
    end
  end

`ifdef SELECT_PERF_EN
  // Saturating handshake and stall counters; survive flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (hs)                    issue_cnt <= sat_inc(issue_cnt);
      if (vld_p0 && !issue_ready) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

  // Allocating a row that is still valid or awaiting wakeup is illegal.
  a_alloc_not_busy: assert property (@(posedge clk) disable iff (!rst)
    !(alloc_en && !flush && busy_vector[alloc_row_index]));

endmodule
